dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single-port, byte-addressed data memory between the CPU load/store port and the UART host port. The UART host reads back results and may preload data. Sits between the RV32I core, the UART controller and the data RAM, replacing the plain `dmem_ctrl` mux. Provides a request/grant handshake per requester, routes one-cycle-latency read data back to the owner, and supports an exclusive host lock.

## Interface
- `ADDR_WIDTH`, default 6: byte address width. Memory holds 2**ADDR_WIDTH bytes as 32-bit words. Must be >= 3.
- `STARVE_LIMIT`, default 8: contested cycles the host may wait before it is forced a slot. Must be >= 1.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_be`  in  4  write byte enables.
- `cpu_addr`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32  write data.
- `cpu_gnt`  out  1  access accepted this cycle (combinational).
- `cpu_rvalid`  out  1  read data valid, registered.
- `cpu_rdata`  out  32  `mem_rdata` pass-through; meaningful only with `cpu_rvalid`.
- `host_req`  in  1  host byte access request; held until `host_gnt`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_WIDTH  byte address.
- `host_wdata`  in  8  write byte.
- `host_gnt`  out  1  access accepted this cycle (combinational).
- `host_rvalid`  out  1  read byte valid, registered.
- `host_rdata`  out  8  byte lane of `mem_rdata` selected by the latched `host_addr[1:0]`.
- `host_lock`  in  1  request exclusive host ownership (driven from CPU-reset state).
- `lock_active`  out  1  exclusive ownership in effect.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  4  RAM byte write enables.
- `mem_addr`  out  ADDR_WIDTH-2  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data, valid one cycle after a read with `mem_en`.

## Operation
- States:
  - NORMAL (reset).
  - DRAIN: lock requested; wait for an in-flight CPU read to return.
  - LOCKED: host only.
- Transitions:
  - NORMAL→DRAIN when `host_lock`=1 and `cpu_rvalid` will be 1 next cycle, i.e. a CPU read was granted this cycle.
  - NORMAL→LOCKED when `host_lock`=1 and no CPU read is in flight.
  - DRAIN→LOCKED after one cycle.
  - LOCKED/DRAIN→NORMAL when `host_lock`=0.
- Grants:
  - NORMAL:
    - Only one requester: grant it.
    - Both requesting: grant the CPU unless `starve_cnt` == STARVE_LIMIT, then grant the host.
  - DRAIN: no grants.
  - LOCKED: host only; `cpu_gnt`=0.
  - At most one grant per cycle.
- Memory drive when granted:
  - CPU: `mem_addr`=`cpu_addr[ADDR_WIDTH-1:2]`, `mem_we`=`cpu_we` ? `cpu_be` : 0, `mem_wdata`=`cpu_wdata`.
  - Host: `mem_addr`=`host_addr[ADDR_WIDTH-1:2]`, `mem_we`=`host_we` ? one-hot(`host_addr[1:0]`) : 0, `mem_wdata`=`{4{host_wdata}}`.
  - `mem_en` = any grant. With no grant, all `mem_*` outputs are 0.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - Increments on each cycle with `host_req`=1 and `host_gnt`=0 while in NORMAL.
  - Saturates at STARVE_LIMIT.
  - Clears on `host_gnt`.
- Read return: a granted read sets the owner's `rvalid` on the next cycle for exactly one cycle. The host byte lane is latched at grant.
- `lock_active`=1 in LOCKED only.

## Timing
- Reset (`rst_n`=0 at an edge): state NORMAL, `starve_cnt`=0, `cpu_rvalid`=0, `host_rvalid`=0, latched lane=0.
- While `rst_n`=0, combinational outputs are forced: `cpu_gnt`=0, `host_gnt`=0, `mem_en`=0, `mem_we`=0, `lock_active`=0.
- Grant to `mem_en`: 0 cycles.
- Read grant to `rvalid`: 1 cycle. Back-to-back reads are sustained at 1 per cycle.
- Requesters must hold request and payload stable until granted. Dropping `req` before grant is permitted (cancel).
- Reset asserted mid-read: a pending `rvalid` is discarded, never emitted.
- `host_lock` dropping during DRAIN: return to NORMAL next cycle; the in-flight CPU `rvalid` is still delivered.

## Configuration
- `ARB_STARVE_GUARD_EN`:
  - Defined: starvation counter and forced host slot as above.
  - Undefined: no counter is built; CPU has strict priority in NORMAL, and the host is granted only when `cpu_req`=0 or in LOCKED.

## Test plan
- Reset: hold `rst_n`=0 with both `req`=1 → no `gnt`, `mem_en`=0, both `rvalid`=0.
- CPU read, addr 0x08: `cpu_gnt`=1 and `mem_addr`=2 same cycle; next cycle `cpu_rvalid`=1 and `cpu_rdata`=`mem_rdata`.
- Host write, addr 0x0D, data 0xA5: `mem_we`=4'b0010, `mem_wdata`=0xA5A5A5A5, `mem_addr`=3.
- Host read, addr 0x0E, `mem_rdata`=0x11223344 → `host_rvalid`=1 and `host_rdata`=0x22 one cycle later.
- Both `req` continuously, guard enabled, STARVE_LIMIT=8 → CPU granted 8 cycles, host granted on cycle 9, then the pattern repeats. Guard disabled → host is never granted.
- `host_lock` asserted in the same cycle a CPU read is granted → DRAIN 1 cycle, `cpu_rvalid` delivered, then LOCKED with `cpu_gnt`=0 despite `cpu_req`=1. Deasserting `host_lock` restores CPU grants next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU load/store port and the UART host port.
// Optional build macro ARB_STARVE_GUARD_EN adds a host starvation counter that forces a host slot.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  // host port
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [7:0]            host_rdata,
  // exclusive host ownership
  input  logic                  host_lock,
  output logic                  lock_active,
  // RAM side
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  // FSM state, for observation only
  output logic [1:0]            dbg_state
);

  // Handshake: a requester raises req with a stable payload and holds it until
  // gnt is seen high in the same cycle; the access is accepted on that clock
  // edge. A granted read returns rvalid exactly one cycle later. Dropping req
  // before gnt cancels the request.

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0] state_q, state_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       host_rvalid_q, host_rvalid_d;
  logic [1:0] lane_q, lane_d;
  logic       force_host;
  logic       cpu_gnt_c, host_gnt_c;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

`ifdef ARB_STARVE_GUARD_EN
  localparam int              CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign force_host = (starve_q == STARVE_MAX);

  // Counts contested NORMAL cycles the host spends waiting; saturates.
  always_comb begin
    starve_d = starve_q;
    if (host_gnt_c) begin
      starve_d = '0;
    end else if (host_req && (state_q == ST_NORMAL) && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_host = 1'b0;
`endif

  // Grant selection; at most one grant per cycle, none while in reset.
  always_comb begin
    cpu_gnt_c  = 1'b0;
    host_gnt_c = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (cpu_req && host_req) begin
          if (force_host) begin
            host_gnt_c = 1'b1;
          end else begin
            cpu_gnt_c = 1'b1;
          end
        end else begin
          cpu_gnt_c  = cpu_req;
          host_gnt_c = host_req;
        end
      end
      ST_LOCKED: begin
        host_gnt_c = host_req;
      end
      default: begin
        cpu_gnt_c  = 1'b0;
        host_gnt_c = 1'b0;
      end
    endcase
    if (!rst_n) begin
      cpu_gnt_c  = 1'b0;
      host_gnt_c = 1'b0;
    end
  end

  assign cpu_gnt  = cpu_gnt_c;
  assign host_gnt = host_gnt_c;

  // Lock entry waits a cycle in DRAIN only if a CPU read is being accepted now.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (host_lock) begin
          state_d = (cpu_gnt_c && !cpu_we) ? ST_DRAIN : ST_LOCKED;
        end
      end
      ST_DRAIN: begin
        state_d = host_lock ? ST_LOCKED : ST_NORMAL;
      end
      ST_LOCKED: begin
        if (!host_lock) begin
          state_d = ST_NORMAL;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  always_comb begin
    cpu_rvalid_d  = cpu_gnt_c && !cpu_we;
    host_rvalid_d = host_gnt_c && !host_we;
    lane_d        = host_gnt_c ? host_addr[1:0] : lane_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_NORMAL;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      lane_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      lane_q        <= lane_d;
    end
  end

  // RAM drive follows the granted requester; everything is zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (cpu_gnt_c) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we ? cpu_be : 4'b0000;
      mem_addr  = cpu_addr[ADDR_WIDTH-1:2];
      mem_wdata = cpu_wdata;
    end else if (host_gnt_c) begin
      mem_en    = 1'b1;
      mem_we    = host_we ? (4'b0001 << host_addr[1:0]) : 4'b0000;
      mem_addr  = host_addr[ADDR_WIDTH-1:2];
      mem_wdata = {4{host_wdata}};
    end
  end

  always_comb begin
    host_rdata = 8'd0;
    case (lane_q)
      2'd0:    host_rdata = mem_rdata[7:0];
      2'd1:    host_rdata = mem_rdata[15:8];
      2'd2:    host_rdata = mem_rdata[23:16];
      default: host_rdata = mem_rdata[31:24];
    endcase
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = mem_rdata;
  assign lock_active = rst_n && (state_q == ST_LOCKED);
  assign dbg_state   = state_q;

  a_one_grant: assert property (@(posedge clk) !(cpu_gnt && host_gnt));
  a_lock_no_cpu: assert property (@(posedge clk) lock_active |-> !cpu_gnt);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: RAM model, driver tasks and
// expected-queue scoreboards for CPU and host read returns.
module tb_dmem_port_arbiter;

  localparam int AW    = 6;
  localparam int LIMIT = 8;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_gnt, host_rvalid;
  logic [7:0]    host_rdata;
  logic          host_lock, lock_active;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    dbg_state;

  int checks;
  int failures;

  logic [31:0] cpu_exp_q[$];
  logic [7:0]  host_exp_q[$];
  logic [31:0] ram[16];
  logic [31:0] ref_mem[16];

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .lock_active(lock_active),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // RAM behaviour model (read-before-write, one cycle latency)
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  // read-return scoreboards
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_exp_q.size() == 0) check_eq("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else check_eq("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
    end
    if (host_rvalid) begin
      if (host_exp_q.size() == 0) check_eq("host_rvalid_unexpected", 32'd1, 32'd0);
      else check_eq("host_rdata", {24'd0, host_rdata}, {24'd0, host_exp_q.pop_front()});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                            input logic [31:0] wd);
    int n;
    logic [3:0] exp_we;
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!cpu_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("cpu_gnt_wait", {31'd0, cpu_gnt}, 32'd1);
    if (cpu_gnt) begin
      exp_we = we ? be : 4'b0000;
      check_eq("cpu_mem_en", {31'd0, mem_en}, 32'd1);
      check_eq("cpu_mem_addr", {28'd0, mem_addr}, {28'd0, addr[AW-1:2]});
      check_eq("cpu_mem_we", {28'd0, mem_we}, {28'd0, exp_we});
      check_eq("cpu_mem_wdata", mem_wdata, wd);
      if (!we) begin
        cpu_exp_q.push_back(ref_mem[addr[AW-1:2]]);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) ref_mem[addr[AW-1:2]][8*i +: 8] = wd[8*i +: 8];
        end
      end
    end
    next_cycle();
    cpu_req = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd);
    int n;
    logic [3:0] exp_we;
    logic [31:0] word;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!host_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("host_gnt_wait", {31'd0, host_gnt}, 32'd1);
    if (host_gnt) begin
      exp_we = we ? (4'b0001 << addr[1:0]) : 4'b0000;
      check_eq("host_mem_en", {31'd0, mem_en}, 32'd1);
      check_eq("host_mem_addr", {28'd0, mem_addr}, {28'd0, addr[AW-1:2]});
      check_eq("host_mem_we", {28'd0, mem_we}, {28'd0, exp_we});
      check_eq("host_mem_wdata", mem_wdata, {4{wd}});
      word = ref_mem[addr[AW-1:2]];
      if (!we) host_exp_q.push_back(word[8*addr[1:0] +: 8]);
      else ref_mem[addr[AW-1:2]][8*addr[1:0] +: 8] = wd;
    end
    next_cycle();
    host_req = 1'b0;
  endtask

  initial begin
    logic exp_host;
    logic [31:0] word;
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    host_lock = 1'b0;

    // reset with both requesting
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("rst_host_gnt", {31'd0, host_gnt}, 32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check_eq("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("rst_lock_active", {31'd0, lock_active}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    next_cycle();
    cpu_req = 1'b0; host_req = 1'b0; rst_n = 1'b1;
    next_cycle();

    // basic CPU and host traffic
    cpu_access(1'b1, 4'b1011, 6'h08, 32'hDEADBEEF);
    cpu_access(1'b0, 4'b0000, 6'h08, 32'd0);
    cpu_access(1'b1, 4'b1111, 6'h0C, 32'h11223344);
    host_access(1'b0, 6'h0E, 8'h00);
    host_access(1'b1, 6'h0D, 8'hA5);
    cpu_access(1'b0, 4'b0000, 6'h0C, 32'd0);
    for (int k = 0; k < 4; k++) begin
      host_access(1'b0, 6'(32'h0C + k), 8'h00);
    end
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) cpu_access(1'b1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), $urandom);
      else host_access(1'b1, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    end
    cpu_access(1'b0, 4'b0000, 6'h10, 32'd0);

    // contention: both request reads continuously
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h0C;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'h0E;
    for (int k = 0; k < 3 * (LIMIT + 1); k++) begin
      @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
      exp_host = ((k % (LIMIT + 1)) == LIMIT);
`else
      exp_host = 1'b0;
`endif
      check_eq("contend_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, ~exp_host});
      check_eq("contend_host_gnt", {31'd0, host_gnt}, {31'd0, exp_host});
      word = ref_mem[3];
      if (exp_host) host_exp_q.push_back(word[23:16]);
      else cpu_exp_q.push_back(word);
      next_cycle();
    end
    cpu_req = 1'b0; host_req = 1'b0;
    next_cycle();
    host_access(1'b0, 6'h0E, 8'h00);

    // lock requested in the same cycle a CPU read is granted
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h08;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'h0E;
    host_lock = 1'b1;
    @(negedge clk);
    check_eq("lock_req_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("lock_req_host_gnt", {31'd0, host_gnt}, 32'd0);
    cpu_exp_q.push_back(ref_mem[2]);
    next_cycle();
    @(negedge clk);
    check_eq("drain_state", {30'd0, dbg_state}, 32'd1);
    check_eq("drain_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("drain_host_gnt", {31'd0, host_gnt}, 32'd0);
    check_eq("drain_lock_active", {31'd0, lock_active}, 32'd0);
    check_eq("drain_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("locked_lock_active", {31'd0, lock_active}, 32'd1);
    check_eq("locked_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("locked_host_gnt", {31'd0, host_gnt}, 32'd1);
    check_eq("locked_mem_addr", {28'd0, mem_addr}, 32'd3);
    word = ref_mem[3];
    host_exp_q.push_back(word[23:16]);
    next_cycle();
    host_req = 1'b0; cpu_addr = 6'h0C;
    @(negedge clk);
    check_eq("locked_idle_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("locked_idle_mem_en", {31'd0, mem_en}, 32'd0);
    next_cycle();
    host_lock = 1'b0;
    @(negedge clk);
    check_eq("unlock_same_cycle_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("unlock_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("unlock_lock_active", {31'd0, lock_active}, 32'd0);
    cpu_exp_q.push_back(ref_mem[3]);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();

    // reset while locked returns to NORMAL
    host_lock = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("relock_lock_active", {31'd0, lock_active}, 32'd1);
    next_cycle();
    rst_n = 1'b0; host_req = 1'b1;
    @(negedge clk);
    check_eq("rst_locked_lock_active", {31'd0, lock_active}, 32'd0);
    check_eq("rst_locked_host_gnt", {31'd0, host_gnt}, 32'd0);
    next_cycle();
    host_lock = 1'b0; host_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("post_rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    next_cycle();
    cpu_access(1'b0, 4'b0000, 6'h0C, 32'd0);

    repeat (3) @(negedge clk);
    check_eq("cpu_queue_drained", cpu_exp_q.size(), 32'd0);
    check_eq("host_queue_drained", host_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
